// File: rtl/huff_bit_packer.sv
// huff_bit_packer: appends Huffman code + VLI bit fields MSB-first and emits 32-bit words.
// Optional macro BYTE_STUFF_EN inserts a 0x00 byte after every 0xFF byte sent to the output.
`ifndef OUT_BUS_WIDTH
`define OUT_BUS_WIDTH 32
`endif

module huff_bit_packer #(
    parameter int OUT_BUS_WIDTH = `OUT_BUS_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              code,
    input  logic [4:0]               code_size,
    input  logic [10:0]              vli_bits,
    input  logic [3:0]               vli_size,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    output logic [OUT_BUS_WIDTH-1:0] data_out,
    output logic [2:0]               out_bytes,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     flush_done
);

    typedef enum logic [1:0] {
        RUN,
        PAD,
        DRAIN
    } state_t;

    state_t      state;
    state_t      state_next;

    // Bit accumulator is left-aligned: bit 47 is the oldest unsent bit.
    logic [47:0] acc;
    logic [47:0] acc_next;
    logic [5:0]  acc_cnt;
    logic [5:0]  acc_cnt_next;

    logic [31:0] asm_word;
    logic [31:0] asm_word_next;
    logic [2:0]  asm_cnt;
    logic [2:0]  asm_cnt_next;

    logic        flush_done_next;

    logic [4:0]  code_len;
    logic [3:0]  vli_len;
    logic [15:0] code_m;
    logic [10:0] vli_m;
    logic [26:0] sym;
    logic [4:0]  sym_len;
    logic [47:0] sym_top;

    logic        accept;
    logic        asm_full;
    logic        drain;
    logic        asm_space;
    logic        have_byte;
    logic [7:0]  acc_byte;
    logic        move;
    logic        take_acc;
    logic [7:0]  move_byte;
    logic        buffers_empty;
    logic [47:0] acc_shift;
    logic [5:0]  base_cnt;

`ifdef BYTE_STUFF_EN
    logic        stuff_pending;
    logic        stuff_pending_next;
`endif

    assign accept    = in_valid && in_ready;
    assign in_ready  = (state == RUN) && (acc_cnt <= 6'd21);
    assign asm_full  = (asm_cnt == 3'd4);
    assign out_valid = asm_full || ((state == DRAIN) && (asm_cnt != 3'd0));
    assign drain     = out_valid && out_ready;
    assign data_out  = asm_word;
    assign out_bytes = out_valid ? asm_cnt : 3'd0;

    // Clamp lengths, mask off bits above each length and left-align the joined symbol.
    always_comb begin
        code_len = (code_size > 5'd16) ? 5'd16 : code_size;
        vli_len  = (vli_size > 4'd11) ? 4'd11 : vli_size;
        code_m   = code & ~(16'hFFFF << code_len);
        vli_m    = vli_bits & ~(11'h7FF << vli_len);
        sym      = ({11'b0, code_m} << vli_len) | {16'b0, vli_m};
        sym_len  = code_len + {1'b0, vli_len};
        sym_top  = {sym, 21'b0} << (5'd27 - sym_len);
    end

    // A residual under 8 bits only leaves during PAD, topped up with 1-bits.
    always_comb begin
        asm_space = !asm_full || drain;
        have_byte = (acc_cnt >= 6'd8) || ((state == PAD) && (acc_cnt != 6'd0));
        acc_byte  = acc[47:40];
        if (acc_cnt < 6'd8) begin
            acc_byte = acc[47:40] | (8'hFF >> acc_cnt[2:0]);
        end
`ifdef BYTE_STUFF_EN
        move               = asm_space && (stuff_pending || have_byte);
        take_acc           = move && !stuff_pending;
        move_byte          = stuff_pending ? 8'h00 : acc_byte;
        buffers_empty      = (acc_cnt == 6'd0) && !stuff_pending;
        stuff_pending_next = stuff_pending;
        if (move) begin
            stuff_pending_next = take_acc && (acc_byte == 8'hFF);
        end
`else
        move          = asm_space && have_byte;
        take_acc      = move;
        move_byte     = acc_byte;
        buffers_empty = (acc_cnt == 6'd0);
`endif
    end

    always_comb begin
        acc_shift = acc;
        base_cnt  = acc_cnt;
        if (take_acc) begin
            acc_shift = acc << 8;
            base_cnt  = (acc_cnt >= 6'd8) ? (acc_cnt - 6'd8) : 6'd0;
        end
        acc_next     = acc_shift;
        acc_cnt_next = base_cnt;
        if (accept) begin
            acc_next     = acc_shift | (sym_top >> base_cnt);
            acc_cnt_next = base_cnt + {1'b0, sym_len};
        end
    end

    // A byte arriving while the full word drains becomes byte 0 of the next word.
    always_comb begin
        asm_word_next = asm_word;
        asm_cnt_next  = asm_cnt;
        if (drain) begin
            asm_word_next = move ? {move_byte, 24'b0} : 32'b0;
            asm_cnt_next  = move ? 3'd1 : 3'd0;
        end else if (move) begin
            asm_word_next = asm_word | ({move_byte, 24'b0} >> {asm_cnt, 3'b000});
            asm_cnt_next  = asm_cnt + 3'd1;
        end
    end

    always_comb begin
        state_next      = state;
        flush_done_next = 1'b0;
        case (state)
            RUN: begin
                if (flush) begin
                    state_next = PAD;
                end
            end
            PAD: begin
                if (buffers_empty) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((asm_cnt == 3'd0) || drain) begin
                    state_next      = RUN;
                    flush_done_next = 1'b1;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            acc        <= 48'b0;
            acc_cnt    <= 6'd0;
            asm_word   <= 32'b0;
            asm_cnt    <= 3'd0;
            flush_done <= 1'b0;
        end else begin
            state      <= state_next;
            acc        <= acc_next;
            acc_cnt    <= acc_cnt_next;
            asm_word   <= asm_word_next;
            asm_cnt    <= asm_cnt_next;
            flush_done <= flush_done_next;
        end
    end

`ifdef BYTE_STUFF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stuff_pending <= 1'b0;
        end else begin
            stuff_pending <= stuff_pending_next;
        end
    end
`endif

endmodule

// File: tb/tb_huff_bit_packer.sv
// tb_huff_bit_packer: directed table-driven bench for huff_bit_packer plus
// hand-written stall, reset-in-drain and empty-flush sequences.
module tb_huff_bit_packer;

    typedef struct packed {
        logic [15:0] c;
        logic [4:0]  cs;
        logic [10:0] v;
        logic [3:0]  vs;
    } sym_t;

    typedef struct {
        string        name;
        int           nsym;
        sym_t [3:0]   syms;
        bit           flush_with;
        int           nwords;
        logic [31:0]  w0;
        logic [2:0]   b0;
        logic [31:0]  w1;
        logic [2:0]   b1;
    } vec_t;

`ifdef BYTE_STUFF_EN
    localparam logic [2:0] FF_BYTES = 3'd2;
`else
    localparam logic [2:0] FF_BYTES = 3'd1;
`endif
    localparam int NV = 8;

    logic        clk;
    logic        rst;
    logic [15:0] code;
    logic [4:0]  code_size;
    logic [10:0] vli_bits;
    logic [3:0]  vli_size;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] data_out;
    logic [2:0]  out_bytes;
    logic        out_valid;
    logic        out_ready;
    logic        flush_done;

    int          checks;
    int          fails;

    logic [31:0] got_words[$];
    logic [2:0]  got_bytes[$];
    int          done_count;
    int          words_at_done;

    vec_t        tbl[NV];
    sym_t        stall_syms[6];
    logic [31:0] exp_words[$];
    logic [2:0]  exp_bytes[$];
    int          idx;
    bit          took;
    logic [31:0] snap;
    bit          seen;

    huff_bit_packer dut (
        .clk       (clk),
        .rst       (rst),
        .code      (code),
        .code_size (code_size),
        .vli_bits  (vli_bits),
        .vli_size  (vli_size),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .data_out  (data_out),
        .out_bytes (out_bytes),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush_done(flush_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted word and the flush_done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                got_words.push_back(data_out);
                got_bytes.push_back(out_bytes);
            end
            if (flush_done) begin
                done_count++;
                words_at_done = got_words.size();
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearMon();
        got_words.delete();
        got_bytes.delete();
        done_count    = 0;
        words_at_done = -1;
    endtask

    task automatic applyStimulus(input sym_t s, input bit with_flush);
        bit accepted;
        accepted  = 1'b0;
        code      = s.c;
        code_size = s.cs;
        vli_bits  = s.v;
        vli_size  = s.vs;
        in_valid  = 1'b1;
        for (int i = 0; i < 100 && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) begin
                flush    = with_flush;
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        if (!accepted) begin
            checks++;
            fails++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 for 100 cycles expected acceptance");
        end
    endtask

    task automatic pulseFlush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic waitDone(input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            #1;
            if (done_count > 0) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            fails++;
            $display("[TB] FAIL done_timeout: got no flush_done within %0d cycles expected a pulse", bound);
        end
        @(posedge clk);
        #1;
    endtask

    // Reference packing: clamp, emit MSB-first, pad with ones, stuff, split into words.
    task automatic buildExpected();
        bit         bq[$];
        logic [7:0] byq[$];
        logic [7:0] by;
        logic [31:0] w;
        int         cl;
        int         vl;
        int         n;
        exp_words.delete();
        exp_bytes.delete();
        for (int k = 0; k < 6; k++) begin
            cl = (stall_syms[k].cs > 5'd16) ? 16 : int'(stall_syms[k].cs);
            vl = (stall_syms[k].vs > 4'd11) ? 11 : int'(stall_syms[k].vs);
            for (int b = cl - 1; b >= 0; b--) bq.push_back(stall_syms[k].c[b]);
            for (int b = vl - 1; b >= 0; b--) bq.push_back(stall_syms[k].v[b]);
        end
        while (bq.size() % 8 != 0) bq.push_back(1'b1);
        for (int i = 0; i < bq.size(); i += 8) begin
            for (int j = 0; j < 8; j++) by[7-j] = bq[i+j];
            byq.push_back(by);
`ifdef BYTE_STUFF_EN
            if (by == 8'hFF) byq.push_back(8'h00);
`endif
        end
        for (int i = 0; i < byq.size(); i += 4) begin
            w = 32'h0;
            n = 0;
            for (int j = 0; j < 4 && (i + j) < byq.size(); j++) begin
                w[31-8*j -: 8] = byq[i+j];
                n++;
            end
            exp_words.push_back(w);
            exp_bytes.push_back(3'(n));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        fails = 0;
        rst = 1'b1;
        code = '0; code_size = '0; vli_bits = '0; vli_size = '0;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        clearMon();

        tbl[0].name = "req033"; tbl[0].nsym = 4; tbl[0].flush_with = 1'b0;
        tbl[0].syms[0] = '{c: 16'h15, cs: 5'd5, v: 11'h1FF, vs: 4'd9};
        tbl[0].syms[1] = '{c: 16'h23, cs: 5'd9, v: 11'h0,   vs: 4'd0};
        tbl[0].syms[2] = '{c: 16'h3,  cs: 5'd2, v: 11'h0,   vs: 4'd1};
        tbl[0].syms[3] = '{c: 16'h15, cs: 5'd5, v: 11'h1FF, vs: 4'd9};
        tbl[0].nwords = 2; tbl[0].w0 = 32'hAFFC47AB; tbl[0].b0 = 3'd4;
        tbl[0].w1 = 32'hFF000000; tbl[0].b1 = FF_BYTES;

        tbl[1].name = "req034"; tbl[1].nsym = 1; tbl[1].flush_with = 1'b0;
        tbl[1].syms[0] = '{c: 16'h3, cs: 5'd2, v: 11'h0, vs: 4'd1};
        tbl[1].nwords = 1; tbl[1].w0 = 32'hDF000000; tbl[1].b0 = 3'd1;
        tbl[1].w1 = 32'h0; tbl[1].b1 = 3'd0;

        tbl[2] = tbl[1];
        tbl[2].name = "req036_flush_with_sym"; tbl[2].flush_with = 1'b1;

        tbl[3].name = "noop_symbol"; tbl[3].nsym = 2; tbl[3].flush_with = 1'b0;
        tbl[3].syms[0] = '{c: 16'hFFFF, cs: 5'd0, v: 11'h7FF, vs: 4'd0};
        tbl[3].syms[1] = '{c: 16'h3,    cs: 5'd2, v: 11'h0,   vs: 4'd1};
        tbl[3].nwords = 1; tbl[3].w0 = 32'hDF000000; tbl[3].b0 = 3'd1;
        tbl[3].w1 = 32'h0; tbl[3].b1 = 3'd0;

        tbl[4].name = "size_clamp"; tbl[4].nsym = 1; tbl[4].flush_with = 1'b0;
        tbl[4].syms[0] = '{c: 16'hABCD, cs: 5'd31, v: 11'h555, vs: 4'd15};
        tbl[4].nwords = 1; tbl[4].w0 = 32'hABCDAABF; tbl[4].b0 = 3'd4;
        tbl[4].w1 = 32'h0; tbl[4].b1 = 3'd0;

        tbl[5].name = "exact_byte_masking"; tbl[5].nsym = 1; tbl[5].flush_with = 1'b0;
        tbl[5].syms[0] = '{c: 16'hFFF5, cs: 5'd4, v: 11'h7F0, vs: 4'd4};
        tbl[5].nwords = 1; tbl[5].w0 = 32'h50000000; tbl[5].b0 = 3'd1;
        tbl[5].w1 = 32'h0; tbl[5].b1 = 3'd0;

        tbl[6].name = "data_ff"; tbl[6].nsym = 1; tbl[6].flush_with = 1'b0;
        tbl[6].syms[0] = '{c: 16'h00FF, cs: 5'd8, v: 11'h0, vs: 4'd0};
        tbl[6].nwords = 1; tbl[6].w0 = 32'hFF000000; tbl[6].b0 = FF_BYTES;
        tbl[6].w1 = 32'h0; tbl[6].b1 = 3'd0;

        tbl[7].name = "pad_ff"; tbl[7].nsym = 1; tbl[7].flush_with = 1'b0;
        tbl[7].syms[0] = '{c: 16'h001F, cs: 5'd5, v: 11'h0, vs: 4'd0};
        tbl[7].nwords = 1; tbl[7].w0 = 32'hFF000000; tbl[7].b0 = FF_BYTES;
        tbl[7].w1 = 32'h0; tbl[7].b1 = 3'd0;

        for (int k = 0; k < 6; k++) begin
            stall_syms[k] = '{c: 16'h1357 + 16'(k) * 16'h2222, cs: 5'd16,
                              v: 11'h4D2 ^ 11'(k), vs: 4'd11};
        end

        // Reset values
        #12;
        checkOutput("rst_data_out", data_out, 32'h0);
        checkOutput("rst_out_bytes", {29'b0, out_bytes}, 32'h0);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("rst_flush_done", {31'b0, flush_done}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_ready_after", {31'b0, in_ready}, 32'h1);
        @(posedge clk);
        #1;

        // Table-driven streams
        for (int t = 0; t < NV; t++) begin
            clearMon();
            out_ready = 1'b1;
            for (int k = 0; k < tbl[t].nsym; k++) begin
                applyStimulus(tbl[t].syms[k], tbl[t].flush_with && (k == tbl[t].nsym - 1));
            end
            if (!tbl[t].flush_with) pulseFlush();
            waitDone(60);
            checkOutput({tbl[t].name, "_nwords"}, got_words.size(), tbl[t].nwords);
            if (got_words.size() >= 1) begin
                checkOutput({tbl[t].name, "_w0"}, got_words[0], tbl[t].w0);
                checkOutput({tbl[t].name, "_b0"}, {29'b0, got_bytes[0]}, {29'b0, tbl[t].b0});
            end
            if (tbl[t].nwords == 2 && got_words.size() >= 2) begin
                checkOutput({tbl[t].name, "_w1"}, got_words[1], tbl[t].w1);
                checkOutput({tbl[t].name, "_b1"}, {29'b0, got_bytes[1]}, {29'b0, tbl[t].b1});
            end
            checkOutput({tbl[t].name, "_done_count"}, done_count, 1);
            checkOutput({tbl[t].name, "_done_after_words"}, words_at_done, tbl[t].nwords);
            repeat (3) @(posedge clk);
            #1;
        end

        // Back-pressure with 27-bit symbols
        buildExpected();
        clearMon();
        out_ready = 1'b0;
        idx = 0;
        snap = 32'h0;
        for (int c = 0; c < 40; c++) begin
            if (idx < 6) begin
                code = stall_syms[idx].c; code_size = stall_syms[idx].cs;
                vli_bits = stall_syms[idx].v; vli_size = stall_syms[idx].vs;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            took = in_valid && in_ready;
            if (c == 25) snap = data_out;
            @(posedge clk);
            #1;
            if (took) idx++;
        end
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("stall_in_ready_low", {31'b0, in_ready}, 32'h0);
        checkOutput("stall_out_valid", {31'b0, out_valid}, 32'h1);
        checkOutput("stall_out_bytes", {29'b0, out_bytes}, 32'h4);
        checkOutput("stall_data_hold", data_out, snap);
        checkOutput("stall_word0", data_out, exp_words[0]);
        checkOutput("stall_accepted_syms", idx, 2);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = idx; k < 6; k++) applyStimulus(stall_syms[k], 1'b0);
        pulseFlush();
        waitDone(200);
        checkOutput("stall_nwords", got_words.size(), exp_words.size());
        for (int i = 0; i < exp_words.size() && i < got_words.size(); i++) begin
            checkOutput($sformatf("stall_word_%0d", i), got_words[i], exp_words[i]);
            checkOutput($sformatf("stall_bytes_%0d", i), {29'b0, got_bytes[i]}, {29'b0, exp_bytes[i]});
        end
        checkOutput("stall_done_count", done_count, 1);
        repeat (3) @(posedge clk);
        #1;

        // Reset during DRAIN
        clearMon();
        out_ready = 1'b0;
        applyStimulus('{c: 16'h3, cs: 5'd2, v: 11'h0, vs: 4'd1}, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checkOutput("drain_partial_valid", {31'b0, out_valid}, 32'h1);
        checkOutput("drain_partial_bytes", {29'b0, out_bytes}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("drain_rst_data_out", data_out, 32'h0);
        checkOutput("drain_rst_out_bytes", {29'b0, out_bytes}, 32'h0);
        checkOutput("drain_rst_out_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("drain_rst_flush_done", {31'b0, flush_done}, 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("drain_rst_no_done", done_count, 0);
        checkOutput("drain_rst_no_words", got_words.size(), 0);
        clearMon();
        applyStimulus('{c: 16'h3, cs: 5'd2, v: 11'h0, vs: 4'd1}, 1'b0);
        pulseFlush();
        waitDone(60);
        checkOutput("post_rst_nwords", got_words.size(), 1);
        if (got_words.size() >= 1) begin
            checkOutput("post_rst_word", got_words[0], 32'hDF000000);
            checkOutput("post_rst_bytes", {29'b0, got_bytes[0]}, 32'h1);
        end
        repeat (3) @(posedge clk);
        #1;

        // Flush with nothing buffered: flush_done two edges after flush is sampled
        clearMon();
        flush = 1'b1;
        @(negedge clk);
        checkOutput("empty_done_c0", {31'b0, flush_done}, 32'h0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        checkOutput("empty_done_c1", {31'b0, flush_done}, 32'h0);
        checkOutput("empty_in_ready_pad", {31'b0, in_ready}, 32'h0);
        @(negedge clk);
        checkOutput("empty_done_c2", {31'b0, flush_done}, 32'h0);
        @(negedge clk);
        checkOutput("empty_done_c3", {31'b0, flush_done}, 32'h1);
        @(negedge clk);
        checkOutput("empty_done_c4", {31'b0, flush_done}, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("empty_no_words", got_words.size(), 0);
        checkOutput("empty_done_count", done_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/huff_bit_packer.md
HUFF_BIT_PACKER -- requirements
Module: huff_bit_packer

Interface
REQ-001 Parameter OUT_BUS_WIDTH, default `OUT_BUS_WIDTH (32), output word width in bits; only 32 is supported.
REQ-002 clk  input  1  single clock; all state on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 code  input  16  Huffman codeword, right-aligned; bits above code_size ignored.
REQ-005 code_size  input  5  codeword length 0..16; values above 16 are treated as 16.
REQ-006 vli_bits  input  11  VLI amplitude bits, right-aligned; bits above vli_size ignored.
REQ-007 vli_size  input  4  VLI length 0..11; values above 11 are treated as 11.
REQ-008 in_valid  input  1  symbol present on code/vli inputs.
REQ-009 in_ready  output  1  packer accepts the symbol this cycle.
REQ-010 flush  input  1  single-cycle end-of-scan request.
REQ-011 data_out  output  32  packed word, first bit of stream at bit 31.
REQ-012 out_bytes  output  3  number of valid leading bytes in data_out (1..4).
REQ-013 out_valid  output  1  data_out/out_bytes valid.
REQ-014 out_ready  input  1  output memory accepts the word.
REQ-015 flush_done  output  1  one-cycle pulse after the final word is accepted.

Function
REQ-016 A symbol is accepted when in_valid and in_ready are both high; its code bits (MSB first), then its VLI bits (MSB first), are appended to a 48-bit accumulator in the following cycle.
REQ-017 in_ready is high only in state RUN and only when the accumulator holds 21 bits or fewer; it is independent of in_valid.
REQ-018 At most one byte per cycle moves from the top of the accumulator into the word assembler, and only when the accumulator holds at least 8 bits and the assembler holds fewer than 4 bytes or is being drained this cycle.
REQ-019 The word assembler fills from bit 31 down; with 4 bytes it raises out_valid with out_bytes=4.
REQ-020 While out_valid is high and out_ready is low, data_out, out_bytes and out_valid hold stable.
REQ-021 A byte may enter the assembler in the same cycle the full word is accepted; it becomes byte 0 of the next word.
REQ-022 States: RUN, PAD, DRAIN. RUN->PAD on flush. PAD->DRAIN once the accumulator is empty. DRAIN->RUN when the final word is accepted, or immediately if the assembler is empty.
REQ-023 If flush and an accepted symbol coincide, the symbol is packed before padding.
REQ-024 In PAD, a residual of 1..7 bits is completed to a full byte with 1-bits; a residual of 0 bits adds nothing.
REQ-025 In DRAIN, a non-empty partial word is presented with out_bytes equal to its byte count and unused bytes zero.
REQ-026 flush_done pulses in the cycle after the DRAIN->RUN transition; with nothing to drain it pulses 2 cycles after flush.
REQ-027 code_size=0 with vli_size=0 is a legal no-op symbol.

Reset
REQ-028 On rst, independent of clk: accumulator empty, assembler empty, state RUN, pending stuff cleared.
REQ-029 On rst: data_out=0, out_bytes=0, out_valid=0, flush_done=0; in_ready=1 in the first cycle after rst deasserts.
REQ-030 rst asserted mid-flush or mid-word discards all buffered bits with no partial word emitted.

Configuration
REQ-031 Macro BYTE_STUFF_EN: when defined, every 0xFF byte moved into the assembler is followed by an inserted 0x00 byte on the next byte move; this inserted byte takes precedence over accumulator bytes and also applies to pad-generated 0xFF.
REQ-032 When BYTE_STUFF_EN is undefined, no bytes are inserted and the stuff-pending logic is absent.

Verification
REQ-033 Feed (0x15/5, 0x1FF/9), (0x23/9, -/0), (0x3/2, 0x0/1), (0x15/5, 0x1FF/9), then flush -> data_out=0xAFFC47AB with out_bytes=4, then 0xFF000000 with out_bytes=2 (BYTE_STUFF_EN) or out_bytes=1 (without), then flush_done.
REQ-034 Feed (0x3/2, 0x0/1), then flush -> data_out=0xDF000000, out_bytes=1, then flush_done.
REQ-035 Hold out_ready=0 with in_valid=1 and 27-bit symbols -> in_ready falls once more than 21 bits are buffered; data_out is stable until out_ready=1; no bits are lost.
REQ-036 Assert flush in the same cycle as the REQ-034 symbol -> same result as REQ-034.
REQ-037 Assert rst during DRAIN -> all outputs 0 immediately; no flush_done; next stream starts at bit 31.
REQ-038 Issue flush with nothing buffered -> no out_valid; flush_done 2 cycles later.
